// File: rtl/id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_ctrl
// Pipeline interlock controller. It drives the stall and flush inputs of the
// IF/ID, ID/EX and EX/MEM segment registers. It resolves three kinds of event:
// load-use hazards between ID and EX, taken branch/jump redirects, and
// data-memory wait states. Two saturating counters record stall and flush
// cycles for performance debug.
//
// Parameters
//   REDIRECT_BUBBLES : wrong-path flush cycles per taken redirect (>= 1)
//   CNT_W            : event counter width
//
// Ports
//   Clk, Rst_n                : clock (rising edge), async active-low reset
//   ID_Rs, ID_Rt              : source registers of the instruction in ID
//   ID_RsRead, ID_RtRead      : source-read qualifiers (RtRead != 0 -> reads Rt)
//   EX_MemWBSrc               : EX instruction is a load
//   EX_Rd_Write_Byte_en       : EX destination byte write enables
//   EX_RegDst, EX_Rt, EX_Rd   : EX destination select and register fields
//   Branch_taken, Jump_taken  : redirect resolved in EX this cycle
//   Mem_busy                  : data memory not ready, freeze everything
//   Cnt_clr                   : synchronous clear of both counters
//   PC_stall .. EX_MEM_stall  : hold the respective register
//   IF_ID_flush, ID_EX_flush  : bubble the respective segment
//   Hz_state                  : 0 RUN, 1 REDIRECT, 2 MEM_WAIT
//   Stall_cnt, Flush_cnt      : saturating event counters
// -----------------------------------------------------------------------------
module id_ex_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_RsRead,
  input  logic [1:0]       ID_RtRead,
  input  logic             EX_MemWBSrc,
  input  logic [3:0]       EX_Rd_Write_Byte_en,
  input  logic [1:0]       EX_RegDst,
  input  logic [4:0]       EX_Rt,
  input  logic [4:0]       EX_Rd,
  input  logic             Branch_taken,
  input  logic             Jump_taken,
  input  logic             Mem_busy,
  input  logic             Cnt_clr,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [1:0]       Hz_state,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt
);

  // Bubble counter only has to hold REDIRECT_BUBBLES-1.
  localparam int BW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
  localparam logic [BW-1:0] RELOAD = BW'(REDIRECT_BUBBLES - 1);
  localparam logic [BW-1:0] BZERO  = BW'(0);
  localparam logic [BW-1:0] BONE   = BW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  hz_state_e state_q, state_d;
  hz_state_e resume_q, resume_d;
  hz_state_e eff_state_s;
  logic [BW-1:0] bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] dest_s;
  logic       dest_vld_s;
  logic       ex_wr_s;
  logic       load_use_s;
  logic       redir_s;

  logic pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s;
  logic if_id_flush_s, id_ex_flush_s;

  // EX destination register decode.
  always_comb begin
    dest_s     = 5'd0;
    dest_vld_s = 1'b0;
    case (EX_RegDst)
      2'd0: begin dest_s = EX_Rt;  dest_vld_s = 1'b1; end
      2'd1: begin dest_s = EX_Rd;  dest_vld_s = 1'b1; end
      2'd2: begin dest_s = 5'd31;  dest_vld_s = 1'b1; end
      default: begin dest_s = 5'd0; dest_vld_s = 1'b0; end
    endcase
  end

  // r0 is never a real producer, so a write to it cannot create a hazard.
  assign ex_wr_s    = (EX_Rd_Write_Byte_en != 4'h0) && dest_vld_s && (dest_s != 5'd0);
  assign load_use_s = EX_MemWBSrc && ex_wr_s &&
                      ((ID_RsRead && (ID_Rs == dest_s)) ||
                       ((ID_RtRead != 2'd0) && (ID_Rt == dest_s)));
  assign redir_s    = Branch_taken || Jump_taken;

  // Next-state, bubble count and stall/flush decode.
  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    bub_d          = bub_q;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;

    // The first non-busy MEM_WAIT cycle acts exactly like the saved state.
    if (state_q == ST_MEM_WAIT) begin
      eff_state_s = resume_q;
    end else begin
      eff_state_s = state_q;
    end

    if (Mem_busy) begin
      // Freeze: bubble count held, remember where to pick up again.
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
      state_d        = ST_MEM_WAIT;
      if (state_q == ST_MEM_WAIT) begin
        resume_d = resume_q;
      end else begin
        resume_d = state_q;
      end
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          if (redir_s) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            bub_d         = RELOAD;
            state_d       = (RELOAD != BZERO) ? ST_REDIRECT : ST_RUN;
          end else if (load_use_s) begin
            // One bubble: hold PC and IF/ID, inject a NOP into ID/EX.
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
            state_d       = ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_REDIRECT: begin
          // load_use is deliberately ignored: the ID instruction is wrong-path.
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          if (redir_s) begin
            bub_d   = RELOAD;
            state_d = (RELOAD != BZERO) ? ST_REDIRECT : ST_RUN;
          end else if (bub_q <= BONE) begin
            bub_d   = BZERO;
            state_d = ST_RUN;
          end else begin
            bub_d   = bub_q - BONE;
            state_d = ST_REDIRECT;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating event counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Cnt_clr) begin
      stall_cnt_d = CNT_ZERO;
      flush_cnt_d = CNT_ZERO;
    end else begin
      if (pc_stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (id_ex_flush_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, resume point, bubble count and counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_RUN;
      resume_q    <= ST_RUN;
      bub_q       <= BZERO;
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // During reset the pipeline is held bubbled: flushes forced, stalls off.
  assign PC_stall     = Rst_n & pc_stall_s;
  assign IF_ID_stall  = Rst_n & if_id_stall_s;
  assign ID_EX_stall  = Rst_n & id_ex_stall_s;
  assign EX_MEM_stall = Rst_n & ex_mem_stall_s;
  assign IF_ID_flush  = (~Rst_n) | if_id_flush_s;
  assign ID_EX_flush  = (~Rst_n) | id_ex_flush_s;
  assign Hz_state     = state_q;
  assign Stall_cnt    = stall_cnt_q;
  assign Flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt, EX_Rd;
  logic       ID_RsRead, EX_MemWBSrc, Branch_taken, Jump_taken, Mem_busy, Cnt_clr;
  logic [1:0] ID_RtRead, EX_RegDst;
  logic [3:0] EX_Rd_Write_Byte_en;
  logic       PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush;
  logic [1:0] Hz_state;
  logic [3:0] Stall_cnt, Flush_cnt;

  id_ex_hazard_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_RsRead(ID_RsRead), .ID_RtRead(ID_RtRead),
    .EX_MemWBSrc(EX_MemWBSrc), .EX_Rd_Write_Byte_en(EX_Rd_Write_Byte_en),
    .EX_RegDst(EX_RegDst), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .Branch_taken(Branch_taken), .Jump_taken(Jump_taken), .Mem_busy(Mem_busy),
    .Cnt_clr(Cnt_clr),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .Hz_state(Hz_state), .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
  );

  always #5 Clk = ~Clk;

  // Expected output bundle: {PC, IF_ID, ID_EX, EX_MEM stalls, IF_ID, ID_EX flushes, Hz_state}
  localparam logic [5:0] O_NONE  = 6'b0000_00;
  localparam logic [5:0] O_LU    = 6'b1100_01;
  localparam logic [5:0] O_FLUSH = 6'b0000_11;
  localparam logic [5:0] O_STALL = 6'b1111_00;

  typedef struct {
    logic       msrc;
    logic [3:0] be;
    logic [1:0] rdst;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       rs_rd;
    logic [1:0] rt_rd;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];
  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [5:0] o, input logic [1:0] hz);
    logic [7:0] act, req;
    #2;
    act = {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, Hz_state};
    req = {o, hz};
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b (stalls4,flushes2,hz2)", name, act, req);
    end
  endtask

  task automatic check_cnt(input string name, input logic [3:0] sc, input logic [3:0] fc);
    n_vec++;
    if ((Stall_cnt !== sc) || (Flush_cnt !== fc)) begin
      n_err++;
      $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d required %0d %0d",
               name, Stall_cnt, Flush_cnt, sc, fc);
    end
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_RsRead = 1'b0; ID_RtRead = 2'd0;
    EX_MemWBSrc = 1'b0; EX_Rd_Write_Byte_en = 4'h0; EX_RegDst = 2'd3;
    EX_Rt = 5'd0; EX_Rd = 5'd0; Branch_taken = 1'b0; Jump_taken = 1'b0;
    Mem_busy = 1'b0; Cnt_clr = 1'b0;
  endtask

  // Load r8 via Rt; ID reads r8 as Rs.
  task automatic load_use_inputs();
    EX_MemWBSrc = 1'b1; EX_Rd_Write_Byte_en = 4'hF; EX_RegDst = 2'd0;
    EX_Rt = 5'd8; ID_Rs = 5'd8; ID_RsRead = 1'b1;
  endtask

  initial begin
    //        msrc  be    rdst   ex_rt  ex_rd  id_rs  id_rt  rs   rt    exp
    tbl[0]  = '{1'b1, 4'hF, 2'd0, 5'd8,  5'd0,  5'd8,  5'd0,  1'b1, 2'd0, O_LU};
    tbl[1]  = '{1'b1, 4'hF, 2'd0, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 2'd0, O_NONE};
    tbl[2]  = '{1'b1, 4'h0, 2'd0, 5'd8,  5'd0,  5'd8,  5'd0,  1'b1, 2'd0, O_NONE};
    tbl[3]  = '{1'b1, 4'hF, 2'd1, 5'd3,  5'd9,  5'd0,  5'd9,  1'b0, 2'd2, O_LU};
    tbl[4]  = '{1'b1, 4'hF, 2'd2, 5'd0,  5'd0,  5'd31, 5'd0,  1'b1, 2'd0, O_LU};
    tbl[5]  = '{1'b1, 4'hF, 2'd3, 5'd8,  5'd8,  5'd8,  5'd8,  1'b1, 2'd1, O_NONE};
    tbl[6]  = '{1'b0, 4'hF, 2'd0, 5'd8,  5'd0,  5'd8,  5'd8,  1'b1, 2'd1, O_NONE};
    tbl[7]  = '{1'b1, 4'hF, 2'd0, 5'd8,  5'd0,  5'd8,  5'd0,  1'b0, 2'd0, O_NONE};
    tbl[8]  = '{1'b1, 4'hF, 2'd0, 5'd12, 5'd0,  5'd1,  5'd12, 1'b1, 2'd1, O_LU};
    tbl[9]  = '{1'b1, 4'h1, 2'd1, 5'd0,  5'd5,  5'd5,  5'd0,  1'b1, 2'd0, O_LU};
    tbl[10] = '{1'b1, 4'hF, 2'd1, 5'd8,  5'd9,  5'd8,  5'd0,  1'b1, 2'd0, O_NONE};
    tbl[11] = '{1'b0, 4'h0, 2'd3, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'd0, O_NONE};

    // Reset state, asserted before any clock edge.
    idle_inputs();
    Rst_n = 1'b0;
    #3;
    check_out("reset_outputs", 6'b0000_11, 2'd0);
    check_cnt("reset_counters", 4'd0, 4'd0);
    tick();
    tick();
    Rst_n = 1'b1;
    check_out("after_reset_idle", O_NONE, 2'd0);

    // Single-cycle load-use decode vectors from RUN.
    for (int i = 0; i < 12; i++) begin
      tick();
      EX_MemWBSrc = tbl[i].msrc; EX_Rd_Write_Byte_en = tbl[i].be; EX_RegDst = tbl[i].rdst;
      EX_Rt = tbl[i].ex_rt; EX_Rd = tbl[i].ex_rd; ID_Rs = tbl[i].id_rs; ID_Rt = tbl[i].id_rt;
      ID_RsRead = tbl[i].rs_rd; ID_RtRead = tbl[i].rt_rd;
      check_out($sformatf("vec%0d", i), tbl[i].exp, 2'd0);
      if (tbl[i].exp == O_LU) begin
        exp_stall++;
        exp_flush++;
      end
    end
    tick();
    idle_inputs();
    check_cnt("table_counters", 4'(exp_stall), 4'(exp_flush));

    // Clear counters, then one load-use: Stall_cnt 0 -> 1.
    Cnt_clr = 1'b1;
    tick();
    Cnt_clr = 1'b0;
    check_cnt("cnt_clr", 4'd0, 4'd0);
    load_use_inputs();
    check_out("lu_single", O_LU, 2'd0);
    tick();
    idle_inputs();
    check_cnt("lu_count", 4'd1, 4'd1);

    // Redirect with load_use also present: exactly 3 flush cycles, no stalls.
    Cnt_clr = 1'b1;
    tick();
    Cnt_clr = 1'b0;
    load_use_inputs();
    Branch_taken = 1'b1;
    check_out("redir_c0", O_FLUSH, 2'd0);
    tick();
    Branch_taken = 1'b0;
    check_out("redir_c1", O_FLUSH, 2'd1);
    tick();
    check_out("redir_c2", O_FLUSH, 2'd1);
    tick();
    idle_inputs();
    check_out("redir_done", O_NONE, 2'd0);
    check_cnt("redir_count", 4'd0, 4'd3);

    // Mem_busy for 4 cycles with one redirect flush cycle left.
    Cnt_clr = 1'b1;
    tick();
    Cnt_clr = 1'b0;
    Jump_taken = 1'b1;
    check_out("mw_redir_c0", O_FLUSH, 2'd0);
    tick();
    Jump_taken = 1'b0;
    check_out("mw_redir_c1", O_FLUSH, 2'd1);
    tick();
    Mem_busy = 1'b1;
    check_out("mw_busy1", O_STALL, 2'd1);
    tick();
    check_out("mw_busy2", O_STALL, 2'd2);
    tick();
    check_out("mw_busy3", O_STALL, 2'd2);
    tick();
    check_out("mw_busy4", O_STALL, 2'd2);
    tick();
    Mem_busy = 1'b0;
    check_out("mw_resume_flush", O_FLUSH, 2'd2);
    tick();
    check_out("mw_back_run", O_NONE, 2'd0);
    check_cnt("mw_counts", 4'd4, 4'd3);

    // Mem_busy beats a redirect in RUN; resume to RUN honours a load-use.
    tick();
    Mem_busy = 1'b1;
    Branch_taken = 1'b1;
    check_out("busy_over_redir", O_STALL, 2'd0);
    tick();
    Mem_busy = 1'b0;
    Branch_taken = 1'b0;
    load_use_inputs();
    check_out("resume_run_lu", O_LU, 2'd2);
    tick();
    idle_inputs();
    check_out("resume_run_idle", O_NONE, 2'd0);

    // Saturation of the 4-bit stall counter, then clear while stalling.
    Cnt_clr = 1'b1;
    tick();
    Cnt_clr = 1'b0;
    Mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_cnt("stall_saturate", 4'hF, 4'd0);
    Cnt_clr = 1'b1;
    tick();
    check_cnt("clr_over_inc", 4'd0, 4'd0);
    Cnt_clr = 1'b0;
    tick();
    check_cnt("count_after_clr", 4'd1, 4'd0);

    // Async reset mid-MEM_WAIT, between edges, with Mem_busy still high.
    #2;
    Rst_n = 1'b0;
    #1;
    check_out("async_rst_mid_wait", 6'b0000_11, 2'd0);
    check_cnt("async_rst_counters", 4'd0, 4'd0);
    tick();
    check_cnt("rst_no_count", 4'd0, 4'd0);
    Rst_n = 1'b1;
    Mem_busy = 1'b0;
    check_out("post_rst_idle", O_NONE, 2'd0);
    tick();
    check_out("post_rst_idle2", O_NONE, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
